// File: rtl/pcieifc_fifo_pkg.sv
// Shared definitions for the PCIe-interface FIFO blocks: read-mode
// constants and the address-width helper.
package pcieifc_fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/pcieifc_sfifo_ram.sv
// Simple dual-port storage for the sync FIFO: one write port, one registered
// read port. The array itself is never reset; only the read register is.
module pcieifc_sfifo_ram
   import pcieifc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 192,
   parameter int DEPTH      = 8,
   parameter int AW         = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value when re is low, so it doubles as dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pcieifc_sync_fifo_ctrl.sv
// Single-clock FIFO controller: wrap-bit pointers, registered count and flags,
// optional first-word-fall-through head stage, sticky error flags and flush.
module pcieifc_sync_fifo_ctrl
   import pcieifc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 192,
   parameter int ADDR_WIDTH = 3,
   parameter int FWFT       = FIFO_MODE_STD,
   parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int              FIFO_DEPTH = 1 << ADDR_WIDTH;
   localparam int              PW         = ADDR_WIDTH + 1;
   localparam logic [PW-1:0]   DEPTH_C    = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0]   AF_C       = PW'(AF_THRESH);
   localparam logic [PW-1:0]   AE_C       = PW'(AE_THRESH);
   localparam bit              IS_FWFT    = (FWFT == FIFO_MODE_FWFT);

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          vld_p1;
   logic          wr_acc, rd_acc, ram_re, vld_nxt, empty_nxt;
   logic [PW-1:0] ram_cnt, wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;

   // In FWFT mode the RAM read register is the head stage: refill it whenever
   // it is empty or being consumed and the RAM holds an already-written word.
   always_comb begin
      wr_acc  = wr_en && !full && !flush;
      rd_acc  = rd_en && !empty && !flush;
      ram_cnt = wr_ptr - rd_ptr;
      if (IS_FWFT) begin
         ram_re  = !flush && (ram_cnt != '0) && (!vld_p1 || rd_acc);
         vld_nxt = !flush && (ram_re || (vld_p1 && !rd_acc));
      end else begin
         ram_re  = rd_acc;
         vld_nxt = 1'b0;
      end
      wr_ptr_nxt = flush ? '0 : wr_ptr + PW'(wr_acc);
      rd_ptr_nxt = flush ? '0 : rd_ptr + PW'(ram_re);
      cnt_nxt    = (wr_ptr_nxt - rd_ptr_nxt) + PW'(vld_nxt);
      empty_nxt  = IS_FWFT ? !vld_nxt : (cnt_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         vld_p1       <= 1'b0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= (AF_THRESH == 0);
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         vld_p1       <= vld_nxt;
         count        <= cnt_nxt;
         empty        <= empty_nxt;
         almost_empty <= (cnt_nxt <= AE_C);
         full         <= (cnt_nxt == DEPTH_C);
         almost_full  <= (cnt_nxt >= AF_C);
         overflow     <= !flush && (overflow || (wr_en && full));
         underflow    <= !flush && (underflow || (rd_en && empty));
      end
   end

   pcieifc_sfifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .AW         (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (din),
      .re    (ram_re),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (dout)
   );

endmodule
